// File: rtl/rv32i_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
// The fetch stage is the master: it drives the address and the strobe. The memory
// acks a strobed request in the same cycle and returns the instruction with the ack.
interface rv32i_fetch_if;
  logic [31:0] o_iaddr;
  logic        o_stb_inst;
  logic        i_ack_inst;
  logic [31:0] i_inst;

  modport master (output o_iaddr, output o_stb_inst, input i_ack_inst, input i_inst);
  modport slave  (input o_iaddr, input o_stb_inst, output i_ack_inst, output i_inst);
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: owns the PC, issues instruction-memory requests and hands
// {pc, inst, ce} to decode. Handles stall, flush and PC redirects, where a writeback
// redirect beats an ALU redirect, which beats sequential fetch.
// Optional feature macro: RV32I_FETCH_MISALIGN_EN. When it is defined, a redirect to a
// non word-aligned target emits a NOP flagged o_misaligned and parks in HALT until
// the next redirect. When it is undefined, redirect targets are word-aligned by
// clearing bits [1:0].
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rv32i_fetch_if.master        imem,
  input  logic                 i_writeback_change_pc,
  input  logic [31:0]          i_writeback_next_pc,
  input  logic                 i_alu_change_pc,
  input  logic [31:0]          i_alu_next_pc,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic [31:0]          o_pc,
  output logic [31:0]          o_inst,
  output logic                 o_ce,
  output logic                 o_misaligned
);

  typedef enum logic [1:0] {
`ifdef RV32I_FETCH_MISALIGN_EN
    S_HALT = 2'd2,
`endif
    S_IDLE = 2'd0,
    S_REQ  = 2'd1
  } state_e;

`ifdef RV32I_FETCH_MISALIGN_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif

  state_e      state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        ce_q, ce_d;
`ifdef RV32I_FETCH_MISALIGN_EN
  logic        mis_q, mis_d;
`endif

  logic        stb;
  logic        ack;
  logic        redirect;
  logic [31:0] target;

  // Next-state and output decode for the fetch FSM and the decode-facing registers.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    iaddr_d  = iaddr_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    ce_d     = ce_q;
`ifdef RV32I_FETCH_MISALIGN_EN
    mis_d    = mis_q;
`endif
    stb      = (state_q == S_REQ) && !i_stall;
    ack      = stb && imem.i_ack_inst;
    redirect = i_writeback_change_pc || i_alu_change_pc;
    target   = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;

    if (redirect) begin
      // A redirect wins over stall, flush and any ack in this cycle.
`ifdef RV32I_FETCH_MISALIGN_EN
      if (target[1:0] != 2'b00) begin
        pc_d    = target;
        inst_d  = NOP;
        ce_d    = 1'b1;
        mis_d   = 1'b1;
        iaddr_d = target;
        state_d = S_HALT;
      end else begin
        iaddr_d = target;
        ce_d    = 1'b0;
        mis_d   = 1'b0;
        state_d = S_REQ;
      end
`else
      iaddr_d = target & 32'hFFFF_FFFC;
      ce_d    = 1'b0;
      state_d = S_REQ;
`endif
    end else if (state_q == S_IDLE) begin
      state_d = S_REQ;
    end else if (state_q == S_REQ) begin
      if (i_flush) begin
        // Kill the output and refetch the same address.
        ce_d = 1'b0;
      end else if (ack) begin
        pc_d    = iaddr_q;
        inst_d  = imem.i_inst;
        ce_d    = 1'b1;
        iaddr_d = iaddr_q + 32'd4;
      end else if (!i_stall) begin
        ce_d = 1'b0;
      end
    end
    // HALT holds every output until a redirect arrives.
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      iaddr_q <= PC_RESET;
      pc_q    <= 32'h0;
      inst_q  <= 32'h0;
      ce_q    <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ce_q    <= ce_d;
`ifdef RV32I_FETCH_MISALIGN_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem.o_iaddr    = iaddr_q;
  assign imem.o_stb_inst = stb;
  assign o_pc            = pc_q;
  assign o_inst          = inst_q;
  assign o_ce            = ce_q;
`ifdef RV32I_FETCH_MISALIGN_EN
  assign o_misaligned    = mis_q;
`else
  assign o_misaligned    = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch. A behavioural memory acks strobed requests
// while ack_en is set and returns addr ^ 32'hA5A5_A5A5. Each accepted fetch pushes
// its expected {pc, inst} into a scoreboard, which is popped when decode output updates.
module tb_rv32i_fetch;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PATTERN  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, ack_en;
  logic        wb_chg, alu_chg;
  logic [31:0] wb_pc, alu_pc;
  logic [31:0] o_pc, o_inst;
  logic        o_ce, o_misaligned;

  rv32i_fetch_if bus ();

  assign bus.i_ack_inst = ack_en & bus.o_stb_inst;
  assign bus.i_inst     = bus.o_iaddr ^ PATTERN;

  rv32i_fetch #(.PC_RESET(PC_RESET)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .imem                  (bus),
    .i_writeback_change_pc (wb_chg),
    .i_writeback_next_pc   (wb_pc),
    .i_alu_change_pc       (alu_chg),
    .i_alu_next_pc         (alu_pc),
    .i_stall               (stall),
    .i_flush               (flush),
    .o_pc                  (o_pc),
    .o_inst                (o_inst),
    .o_ce                  (o_ce),
    .o_misaligned          (o_misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic        in_req, halted;
  logic [31:0] exp_addr, exp_pc, exp_inst;
  logic        exp_ce, exp_mis;
  logic [63:0] sb[$];

  task automatic model_reset();
    in_req   = 1'b0;
    halted   = 1'b0;
    exp_addr = PC_RESET;
    exp_ce   = 1'b0;
    exp_mis  = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: predict from the driven inputs, clock, then compare.
  task automatic tick(input string tag);
    logic        exp_stb, acc;
    logic [31:0] tgt;
    logic [63:0] e;
    #1;
    exp_stb = in_req && !stall;
    acc     = 1'b0;
    total++;
    if (bus.o_stb_inst !== exp_stb) begin
      bad++;
      $display("FAIL %s stb: got %b want %b", tag, bus.o_stb_inst, exp_stb);
    end
    if (wb_chg || alu_chg) begin
      tgt = wb_chg ? wb_pc : alu_pc;
`ifdef RV32I_FETCH_MISALIGN_EN
      if (tgt[1:0] != 2'b00) begin
        exp_pc = tgt; exp_inst = 32'h0000_0013; exp_ce = 1'b1; exp_mis = 1'b1;
        exp_addr = tgt; in_req = 1'b0; halted = 1'b1;
      end else begin
        exp_addr = tgt; exp_ce = 1'b0; exp_mis = 1'b0; in_req = 1'b1; halted = 1'b0;
      end
`else
      exp_addr = {tgt[31:2], 2'b00};
      exp_ce   = 1'b0;
      in_req   = 1'b1;
`endif
    end else if (!in_req) begin
      if (!halted) in_req = 1'b1;
    end else if (flush) begin
      exp_ce = 1'b0;
    end else if (ack_en && exp_stb) begin
      sb.push_back({exp_addr, exp_addr ^ PATTERN});
      exp_addr = exp_addr + 32'd4;
      exp_ce   = 1'b1;
      acc      = 1'b1;
    end else if (!stall) begin
      exp_ce = 1'b0;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      e = sb.pop_front();
      exp_pc   = e[63:32];
      exp_inst = e[31:0];
    end
    total++;
    if (o_ce !== exp_ce) begin
      bad++;
      $display("FAIL %s ce: got %b want %b", tag, o_ce, exp_ce);
    end
    total++;
    if (bus.o_iaddr !== exp_addr) begin
      bad++;
      $display("FAIL %s iaddr: got %h want %h", tag, bus.o_iaddr, exp_addr);
    end
    total++;
    if (o_misaligned !== exp_mis) begin
      bad++;
      $display("FAIL %s misaligned: got %b want %b", tag, o_misaligned, exp_mis);
    end
    if (exp_ce) begin
      total++;
      if (o_pc !== exp_pc || o_inst !== exp_inst) begin
        bad++;
        $display("FAIL %s pc/inst: got %h/%h want %h/%h", tag, o_pc, o_inst, exp_pc, exp_inst);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (bus.o_stb_inst !== 1'b0 || bus.o_iaddr !== PC_RESET || o_ce !== 1'b0 ||
        o_pc !== 32'h0 || o_inst !== 32'h0 || o_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL %s: got stb=%b iaddr=%h ce=%b pc=%h inst=%h mis=%b want 0/%h/0/0/0/0",
               tag, bus.o_stb_inst, bus.o_iaddr, o_ce, o_pc, o_inst, o_misaligned, PC_RESET);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_reset_state("reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    ack_en = 1'b1;
    tick("idle");
    for (int i = 0; i < 3; i++) tick("seq");
  endtask

  task automatic test_ack_wait();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) tick("ack_wait");
    ack_en = 1'b1;
    tick("ack_resume");
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) tick("stall");
    stall = 1'b0;
    for (int i = 0; i < 2; i++) tick("stall_resume");
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
    tick("flush_after");
    stall = 1'b1; flush = 1'b1;
    tick("flush_over_stall");
    stall = 1'b0; flush = 1'b0;
    tick("flush_stall_after");
  endtask

  task automatic test_redirect();
    alu_chg = 1'b1; alu_pc = 32'h0000_0100;
    wb_chg  = 1'b1; wb_pc  = 32'h0000_0200;
    tick("redirect_prio");
    alu_chg = 1'b0; wb_chg = 1'b0;
    tick("redirect_fetch");
    stall = 1'b1;
    alu_chg = 1'b1; alu_pc = 32'h0000_0040;
    tick("redirect_in_stall");
    alu_chg = 1'b0; stall = 1'b0;
    tick("redirect_stall_fetch");
  endtask

  task automatic test_wrap();
    wb_chg = 1'b1; wb_pc = 32'hFFFF_FFFC;
    tick("wrap_redirect");
    wb_chg = 1'b0;
    tick("wrap_top");
    tick("wrap_zero");
  endtask

  task automatic test_misalign();
    alu_chg = 1'b1; alu_pc = 32'h0000_0102;
    tick("misalign_redirect");
    alu_chg = 1'b0;
    tick("misalign_next");
    tick("misalign_hold");
    alu_chg = 1'b1; alu_pc = 32'h0000_0300;
    tick("misalign_exit");
    alu_chg = 1'b0;
    tick("misalign_fetch");
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("reset_mid_idle");
    tick("reset_mid_fetch");
    tick("reset_mid_fetch2");
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ack_en = 1'b0;
    wb_chg = 1'b0; alu_chg = 1'b0; wb_pc = 32'h0; alu_pc = 32'h0;
    model_reset();
    test_reset();
    test_sequential();
    test_ack_wait();
    test_stall();
    test_flush();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
